// File: rtl/wordser_pkg.sv
// -----------------------------------------------------------------------------
// wordser_pkg
// Shared definitions for the word-to-lane serializer:
//   IDLE_SYM       idle fill byte driven on Data_out while no lane is valid
//                  (only used when WORDSER_IDLE_FILL_EN is defined)
//   IDLE_SYM_WIDE  IDLE_SYM replicated so any lane width up to 256 bits can
//                  take its low OUT_W bits (replicate or truncate)
//   ser_state_e    serializer FSM states
//   lanes_per_word returns IN_W/OUT_W, or 0 when the ratio is illegal
// -----------------------------------------------------------------------------
package wordser_pkg;

    localparam logic [7:0]   IDLE_SYM      = 8'hBC;
    localparam logic [255:0] IDLE_SYM_WIDE = {32{IDLE_SYM}};

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_e;

    // Lanes per word; 0 flags an illegal ratio (non-multiple or fewer than 2 lanes).
    function automatic int lanes_per_word(input int in_w, input int out_w);
        int r;
        if (out_w <= 0) begin
            r = 0;
        end else if ((in_w % out_w) != 0) begin
            r = 0;
        end else if ((in_w / out_w) < 2) begin
            r = 0;
        end else begin
            r = in_w / out_w;
        end
        return r;
    endfunction

endpackage

// File: rtl/word_fifo.sv
// -----------------------------------------------------------------------------
// word_fifo
// Synchronous DEPTH x W word FIFO. Pushes while full and pops while empty are
// ignored, so callers may drive push/pop without gating.
// Ports:
//   clk_4f   in   clock, all state on rising edge
//   reset_L  in   asynchronous active-low reset (pointers and count cleared)
//   push     in   write din at the edge (ignored when full)
//   pop      in   advance the head at the edge (ignored when empty)
//   din      in   W-bit write data
//   dout     out  W-bit head word (valid when !empty)
//   count    out  words buffered, $clog2(DEPTH)+1 bits
//   full     out  count == DEPTH
//   empty    out  count == 0
// -----------------------------------------------------------------------------
module word_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk_4f,
    input  logic                     reset_L,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int             AW        = $clog2(DEPTH);
    localparam logic [AW:0]    DEPTH_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic [AW:0]   count_nxt_s;
    logic          push_ok_s;
    logic          pop_ok_s;

    assign full      = (count_r == DEPTH_CNT);
    assign empty     = (count_r == {(AW+1){1'b0}});
    assign count     = count_r;
    assign dout      = mem_r[rd_ptr_r];
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;

    // Next occupancy: simultaneous push and pop leaves the count unchanged.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_nxt_s = count_r + (AW+1)'(1'b1);
            2'b01:   count_nxt_s = count_r - (AW+1)'(1'b1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointer and occupancy registers; pointers wrap modulo DEPTH.
    always_ff @(posedge clk_4f or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            count_r <= count_nxt_s;
        end
    end

    // Storage array; contents are only meaningful between the pointers.
    always_ff @(posedge clk_4f) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

endmodule

// File: rtl/wordn_serializer.sv
// -----------------------------------------------------------------------------
// wordn_serializer
// Buffers IN_W-bit words in a DEPTH-entry FIFO and emits them as OUT_W-bit
// lanes, one per clk_4f cycle, stalling on ready and flagging dropped words.
// Optional build macro: WORDSER_IDLE_FILL_EN -- when defined, Data_out drives
// IDLE_SYM (replicated/truncated to OUT_W) whenever valid_out is 0, including
// during reset; otherwise it drives 0.
// Ports:
//   clk_4f      in   lane-rate clock
//   reset_L     in   asynchronous active-low reset
//   valid_in    in   Data_in holds a word this cycle
//   Data_in     in   IN_W-bit word
//   full        out  FIFO holds DEPTH words; an offered word is dropped
//   overflow    out  sticky: a word was offered while full
//   fifo_count  out  words buffered, excluding the one being serialized
//   ready       in   downstream accepts the lane this cycle
//   valid_out   out  Data_out holds a valid lane
//   Data_out    out  OUT_W-bit lane
// -----------------------------------------------------------------------------
module wordn_serializer
    import wordser_pkg::*;
#(
    parameter int IN_W      = 32,
    parameter int OUT_W     = 8,
    parameter int DEPTH     = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic                    clk_4f,
    input  logic                    reset_L,
    input  logic                    valid_in,
    input  logic [IN_W-1:0]         Data_in,
    output logic                    full,
    output logic                    overflow,
    output logic [$clog2(DEPTH):0]  fifo_count,
    input  logic                    ready,
    output logic                    valid_out,
    output logic [OUT_W-1:0]        Data_out
);

    localparam int R  = lanes_per_word(IN_W, OUT_W);
    localparam int CW = (R > 2) ? $clog2(R) : 1;
    localparam logic [CW-1:0] LAST_LANE = CW'(R - 1);

`ifdef WORDSER_IDLE_FILL_EN
    localparam logic [OUT_W-1:0] IDLE_FILL = IDLE_SYM_WIDE[OUT_W-1:0];
`else
    localparam logic [OUT_W-1:0] IDLE_FILL = {OUT_W{1'b0}};
`endif

    if (R < 2) begin : g_bad_ratio
        $fatal(1, "wordn_serializer: IN_W must be a multiple of OUT_W with at least 2 lanes");
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $fatal(1, "wordn_serializer: DEPTH must be a power of two, at least 2");
    end

    ser_state_e        state_r;
    ser_state_e        state_nxt_s;
    logic [CW-1:0]     cnt_r;
    logic [IN_W-1:0]   shift_r;
    logic [IN_W-1:0]   shifted_s;
    logic [IN_W-1:0]   fifo_head_s;
    logic [OUT_W-1:0]  cur_lane_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic              load_s;
    logic              advance_s;
    logic              valid_s;
    logic [OUT_W-1:0]  lane_s;
    logic              overflow_r;

    word_fifo #(
        .W     (IN_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_4f  (clk_4f),
        .reset_L (reset_L),
        .push    (valid_in),
        .pop     (load_s),
        .din     (Data_in),
        .dout    (fifo_head_s),
        .count   (fifo_count),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s)
    );

    // The lane on the wire always sits at the leading end of the shift register.
    assign cur_lane_s = (MSB_FIRST != 0) ? shift_r[IN_W-1 -: OUT_W] : shift_r[OUT_W-1:0];
    assign shifted_s  = (MSB_FIRST != 0) ? {shift_r[IN_W-OUT_W-1:0], {OUT_W{1'b0}}}
                                         : {{OUT_W{1'b0}}, shift_r[IN_W-1:OUT_W]};

    assign full      = fifo_full_s;
    assign overflow  = overflow_r;
    assign valid_out = valid_s;
    assign Data_out  = lane_s;

    // FSM state register.
    always_ff @(posedge clk_4f or negedge reset_L) begin
        if (!reset_L) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and pop/shift decisions; the last lane reloads with no bubble.
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        advance_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (!fifo_empty_s) begin
                    state_nxt_s = SEND;
                    load_s      = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SEND: begin
                if (!ready) begin
                    state_nxt_s = SEND;
                end else if (cnt_r != LAST_LANE) begin
                    advance_s   = 1'b1;
                end else if (!fifo_empty_s) begin
                    load_s      = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Outputs decoded from the state and shift registers only.
    always_comb begin
        valid_s = 1'b0;
        lane_s  = IDLE_FILL;
        case (state_r)
            SEND: begin
                valid_s = 1'b1;
                lane_s  = cur_lane_s;
            end
            IDLE: begin
                valid_s = 1'b0;
                lane_s  = IDLE_FILL;
            end
            default: begin
                valid_s = 1'b0;
                lane_s  = IDLE_FILL;
            end
        endcase
    end

    // Shift register and lane counter.
    always_ff @(posedge clk_4f or negedge reset_L) begin
        if (!reset_L) begin
            shift_r <= {IN_W{1'b0}};
            cnt_r   <= {CW{1'b0}};
        end else if (load_s) begin
            shift_r <= fifo_head_s;
            cnt_r   <= {CW{1'b0}};
        end else if (advance_s) begin
            shift_r <= shifted_s;
            cnt_r   <= cnt_r + CW'(1'b1);
        end else begin
            shift_r <= shift_r;
            cnt_r   <= cnt_r;
        end
    end

    // Sticky drop flag, cleared only by reset.
    always_ff @(posedge clk_4f or negedge reset_L) begin
        if (!reset_L) begin
            overflow_r <= 1'b0;
        end else if (valid_in && fifo_full_s) begin
            overflow_r <= 1'b1;
        end else begin
            overflow_r <= overflow_r;
        end
    end

endmodule
